// File: rtl/spi_input_frontend.sv
// spi_input_frontend: synchronises and debounces the raw SPI pins and emits single-cycle edge strobes.
// Optional macro GLITCH_CNT_EN adds glitch_count, a saturating count of rejected glitches.
module spi_fe_chan #(
    parameter int WAIT  = 3,
    parameter int CNT_W = 4,
    parameter bit IDLE  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic c_d,
    output logic c_q
`ifdef GLITCH_CNT_EN
    ,
    output logic abort
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT - 1);

    logic             s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match;

    assign match = (s2_q == c_q);

    always_comb begin
        s1_d  = pin;
        s2_d  = s1_q;
        cnt_d = cnt_q;
        c_d   = c_q;
        if (match) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            c_d   = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef GLITCH_CNT_EN
    // A partial count thrown away because the line settled back.
    assign abort = match && (cnt_q != '0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= IDLE;
            s2_q  <= IDLE;
            cnt_q <= '0;
            c_q   <= IDLE;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            cnt_q <= cnt_d;
            c_q   <= c_d;
        end
    end
endmodule

module spi_input_frontend #(
    parameter int WAIT  = 3,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       sclk_c,
    output logic       cs_c,
    output logic       mosi_c,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       sclk_rise_sel,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       mosi_bit
`ifdef GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);
    localparam int NCH = 3;
    // Channel order {mosi, cs, sclk}; cs idles high.
    localparam logic [NCH-1:0] IDLE_V = 3'b010;

    logic [NCH-1:0] pin, c_d, c_q;
`ifdef GLITCH_CNT_EN
    logic [NCH-1:0] abort;
`endif

    assign pin = {mosi_pin, cs_pin, sclk_pin};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        spi_fe_chan #(
            .WAIT (WAIT),
            .CNT_W(CNT_W),
            .IDLE (IDLE_V[i])
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (pin[i]),
            .c_d    (c_d[i]),
            .c_q    (c_q[i])
`ifdef GLITCH_CNT_EN
            ,
            .abort  (abort[i])
`endif
        );
    end

    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
    logic sel_q, sel_d, mosi_bit_q, mosi_bit_d;

    // Pulses are decoded from the next-state view so they appear the cycle after the flip.
    always_comb begin
        sclk_rise_d = c_d[0] & ~c_q[0];
        sclk_fall_d = ~c_d[0] & c_q[0];
        cs_rise_d   = c_d[1] & ~c_q[1];
        cs_fall_d   = ~c_d[1] & c_q[1];
        sel_d       = sclk_rise_d & ~c_d[1];
        mosi_bit_d  = sel_d ? c_d[2] : mosi_bit_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            sel_q       <= 1'b0;
            mosi_bit_q  <= 1'b0;
        end else begin
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            sel_q       <= sel_d;
            mosi_bit_q  <= mosi_bit_d;
        end
    end

    assign sclk_c        = c_q[0];
    assign cs_c          = c_q[1];
    assign mosi_c        = c_q[2];
    assign sclk_rise     = sclk_rise_q;
    assign sclk_fall     = sclk_fall_q;
    assign sclk_rise_sel = sel_q;
    assign cs_fall       = cs_fall_q;
    assign cs_rise       = cs_rise_q;
    assign mosi_bit      = mosi_bit_q;

`ifdef GLITCH_CNT_EN
    logic [7:0] gcnt_q, gcnt_d;
    logic [1:0] n_abort;
    logic [8:0] gsum;

    always_comb begin
        n_abort = 2'(abort[0]) + 2'(abort[1]) + 2'(abort[2]);
        gsum    = {1'b0, gcnt_q} + 9'(n_abort);
        gcnt_d  = gsum[8] ? 8'hFF : gsum[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gcnt_q <= 8'h00;
        else          gcnt_q <= gcnt_d;
    end

    assign glitch_count = gcnt_q;
`endif
endmodule

// File: tb/tb_spi_input_frontend.sv
// Randomised + directed bench for spi_input_frontend against a window-based reference model.
// Build with GLITCH_CNT_EN defined to also check glitch_count.
module tb_spi_input_frontend;
    localparam int WAIT = 3;
    localparam bit [2:0] IDLE = 3'b010;  // {mosi, cs, sclk}

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk_pin = 1'b0, cs_pin = 1'b1, mosi_pin = 1'b0;
    logic sclk_c, cs_c, mosi_c, sclk_rise, sclk_fall, sclk_rise_sel, cs_fall, cs_rise, mosi_bit;
`ifdef GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    always #5 clk = ~clk;

    spi_input_frontend #(.WAIT(WAIT), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sclk_pin     (sclk_pin),
        .cs_pin       (cs_pin),
        .mosi_pin     (mosi_pin),
        .sclk_c       (sclk_c),
        .cs_c         (cs_c),
        .mosi_c       (mosi_c),
        .sclk_rise    (sclk_rise),
        .sclk_fall    (sclk_fall),
        .sclk_rise_sel(sclk_rise_sel),
        .cs_fall      (cs_fall),
        .cs_rise      (cs_rise),
        .mosi_bit     (mosi_bit)
`ifdef GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a line takes a new value once its synchronised input has
    // disagreed with it on each of the last WAIT edges since it last changed.
    bit pq[3][$];          // pin value sampled at each edge since reset
    int n;                 // edges since reset release
    int lastf[3];
    bit [2:0] mc;
    bit e_srise, e_sfall, e_crise, e_cfall, e_sel, mb;
    int gc;

    function automatic bit s2f(int ch, int k);
        return (k >= 3) ? pq[ch][k-3] : IDLE[ch];
    endfunction

    task automatic mdl_reset();
        for (int ch = 0; ch < 3; ch++) begin
            pq[ch].delete();
            lastf[ch] = 0;
        end
        n = 0; mc = IDLE; mb = 1'b0; gc = 0;
        {e_srise, e_sfall, e_crise, e_cfall, e_sel} = '0;
    endtask

    task automatic mdl_edge(input bit [2:0] p);
        bit [2:0] rs, fl;
        int na;
        n++; na = 0;
        for (int ch = 0; ch < 3; ch++) begin
            bit flip, cur;
            pq[ch].push_back(p[ch]);
            cur  = mc[ch];
            flip = (n - lastf[ch] >= WAIT);
            for (int j = 0; j < WAIT; j++) if (s2f(ch, n - j) == cur) flip = 1'b0;
            if (s2f(ch, n) == cur && s2f(ch, n - 1) != cur) na++;
            rs[ch] = flip & ~cur;
            fl[ch] = flip & cur;
            if (flip) begin
                mc[ch] = ~cur;
                lastf[ch] = n;
            end
        end
        e_srise = rs[0]; e_sfall = fl[0]; e_crise = rs[1]; e_cfall = fl[1];
        e_sel = rs[0] & ~mc[1];
        if (e_sel) mb = mc[2];
        gc = (gc + na > 255) ? 255 : gc + na;
    endtask

    task automatic cmp_all();
        chk("sclk_c", sclk_c, mc[0]);
        chk("cs_c", cs_c, mc[1]);
        chk("mosi_c", mosi_c, mc[2]);
        chk("sclk_rise", sclk_rise, e_srise);
        chk("sclk_fall", sclk_fall, e_sfall);
        chk("cs_rise", cs_rise, e_crise);
        chk("cs_fall", cs_fall, e_cfall);
        chk("sclk_rise_sel", sclk_rise_sel, e_sel);
        chk("mosi_bit", mosi_bit, mb);
`ifdef GLITCH_CNT_EN
        chk("glitch_count", glitch_count, gc);
`endif
    endtask

    // Observed-event tallies for the directed scenarios.
    int cnt_sr, cnt_sf, cnt_cr, cnt_cf, cnt_sel, cnt_schi, cnt_nonidle, first_cs0;
    int sel_edge[$];
    bit mbq[$];

    task automatic clr_tally();
        {cnt_sr, cnt_sf, cnt_cr, cnt_cf, cnt_sel, cnt_schi, cnt_nonidle} = '0;
        first_cs0 = -1;
        sel_edge.delete();
        mbq.delete();
    endtask

    task automatic tally();
        cnt_sr += int'(sclk_rise);
        cnt_sf += int'(sclk_fall);
        cnt_cr += int'(cs_rise);
        cnt_cf += int'(cs_fall);
        cnt_schi += int'(sclk_c);
        if ({mosi_c, cs_c, sclk_c} != IDLE) cnt_nonidle++;
        if (sclk_rise_sel) begin
            cnt_sel++;
            sel_edge.push_back(n);
            mbq.push_back(mosi_bit);
        end
        if (!cs_c && first_cs0 < 0) first_cs0 = n;
    endtask

    task automatic step(input bit rn, input bit sc, input bit cs, input bit mo);
        @(negedge clk);
        reset_n = rn; sclk_pin = sc; cs_pin = cs; mosi_pin = mo;
        if (!rn) begin
            mdl_reset();
            #1 cmp_all();
        end
        @(posedge clk);
        if (rn) mdl_edge({mo, cs, sc});
        #1 cmp_all();
        tally();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    int seq[4] = '{1, 0, 1, 1};
    int rise_e[$];
    bit [2:0] pv;
    int tm[3];

    initial begin
        mdl_reset();

        // cs falls after reset: appears on cs_c at edge 2+WAIT
        do_reset();
        clr_tally();
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cs_fall_edge", first_cs0, 2 + WAIT);
        chk("cs_fall_cnt", cnt_cf, 1);
        chk("other_pulses", cnt_sr + cnt_sf + cnt_cr + cnt_sel, 0);

        // selected sclk frames with mosi 1,0,1,1
        clr_tally();
        rise_e.delete();
        for (int b = 0; b < 4; b++) begin
            int prev;
            prev = (b == 0) ? 0 : seq[b-1];
            repeat (4) step(1'b1, 1'b0, 1'b0, prev[0]);
            repeat (4) step(1'b1, 1'b0, 1'b0, seq[b][0]);
            rise_e.push_back(n + 1);
            repeat (8) step(1'b1, 1'b1, 1'b0, seq[b][0]);
        end
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("sel_cnt", cnt_sel, 4);
        chk("sclk_fall_cnt", cnt_sf, 4);
        chk("mbq_size", mbq.size(), 4);
        for (int i = 0; i < 4 && i < mbq.size(); i++) begin
            chk("mosi_seq", mbq[i], seq[i]);
            chk("sel_latency", sel_edge[i] - rise_e[i], WAIT + 1);
        end

        // 2-clk sclk glitch is rejected
        do_reset();
        clr_tally();
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("glitch_no_rise", cnt_sr, 0);
        chk("glitch_sclk_hi", cnt_schi, 0);
`ifdef GLITCH_CNT_EN
        chk("glitch_cnt1", glitch_count, 1);
`endif

        // deselected sclk: rises counted, nothing captured
        do_reset();
        clr_tally();
        for (int k = 0; k < 4; k++) begin
            repeat (8) step(1'b1, 1'b0, 1'b1, 1'b1);
            repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1);
        end
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("desel_rise", cnt_sr, 4);
        chk("desel_sel", cnt_sel, 0);
        chk("desel_mbit", mosi_bit, 0);

        // reset in the middle of a cs debounce
        do_reset();
        clr_tally();
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_cs_c", cs_c, 1);
        chk("midrst_no_fall", cnt_cf, 0);
        clr_tally();
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_fall_edge", first_cs0, 2 + WAIT);
        chk("midrst_fall_cnt", cnt_cf, 1);

        // 300 single-cycle glitches on every pin
        do_reset();
        clr_tally();
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("glitch_lines_idle", cnt_nonidle, 0);
`ifdef GLITCH_CNT_EN
        chk("glitch_sat", glitch_count, 255);
`endif

        // random pin activity with occasional resets
        do_reset();
        pv = IDLE;
        tm = '{0, 0, 0};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                step(1'b0, pv[0], pv[1], pv[2]);
            end else begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (tm[ch] == 0) begin
                        pv[ch] = 1'($urandom_range(0, 1));
                        tm[ch] = $urandom_range(1, (ch == 1) ? 40 : 9);
                    end
                    tm[ch]--;
                end
                step(1'b1, pv[0], pv[1], pv[2]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_input_frontend.md
Name: spi_input_frontend

Overview:
- Upstream conditioning stage for the SPI memory FSM and its shift register.
- Synchronises the raw asynchronous pins sclk, cs and mosi into the clk domain and debounces each one.
- Produces single-cycle edge strobes: the FSM and shift register advance on sclk edges and react to cs edges.
- Also latches the mosi bit on each selected sclk rising edge.

Parameters:
- WAIT, 3: consecutive mismatching clk edges needed before a conditioned line flips. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 4: width of each per-channel debounce counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sclk_pin  in  1  raw SPI clock pin.
- cs_pin  in  1  raw chip-select pin, active low.
- mosi_pin  in  1  raw master-out data pin.
- sclk_c  out  1  conditioned sclk.
- cs_c  out  1  conditioned cs.
- mosi_c  out  1  conditioned mosi.
- sclk_rise  out  1  one-cycle pulse when sclk_c goes 0->1.
- sclk_fall  out  1  one-cycle pulse when sclk_c goes 1->0.
- sclk_rise_sel  out  1  sclk_rise gated by cs_c==0.
- cs_fall  out  1  one-cycle pulse on cs_c 1->0 (frame start).
- cs_rise  out  1  one-cycle pulse on cs_c 0->1 (frame end).
- mosi_bit  out  1  mosi_c value captured when sclk_rise_sel fires.
- glitch_count  out  8  rejected-glitch counter. Present only with GLITCH_CNT_EN.

Behaviour:
- Reset values (asynchronous on reset_n=0):
  - sync flops and conditioned outputs at idle: sclk=0, cs=1, mosi=0.
  - all counters 0, all pulse outputs 0, mosi_bit=0.
- Identical channel for each pin:
  - 2-flop synchroniser: s1 <= pin, s2 <= s1.
  - Debounce state: counter cnt plus conditioned register c.
- Per channel, each edge:
  - If s2==c: cnt <= 0. If cnt was nonzero, this cycle is a glitch abort.
  - Else if cnt==WAIT-1: c <= s2, cnt <= 0, fire the matching edge pulse on this same edge.
  - Else: cnt <= cnt+1.
- Latency: a clean pin transition ahead of edge 1 appears on c at edge 2+WAIT (5 with the default). The pulse is high for exactly the cycle after that edge.
- All pulses are registered and never wider than one cycle. A line cannot produce consecutive pulses closer than WAIT cycles apart.
- sclk_rise_sel = sclk_rise AND cs_c==0, both registered values from the same edge.
  - If cs_fall and sclk_rise fire in the same cycle, cs_c is already 0, so sclk_rise_sel fires.
  - If cs_rise and sclk_rise coincide, sclk_rise_sel stays 0.
- mosi_bit takes the post-edge mosi_c whenever sclk_rise_sel is generated, and holds otherwise. If mosi_c and sclk_c flip on the same edge, the new mosi_c is captured.
- Channels are independent; simultaneous events on different channels are all honoured.
- Reset mid-debounce: the counter is discarded and no pulse is generated.
- After reset deassertion, a pin differing from its idle value gets the normal 2+WAIT latency and produces the corresponding edge pulse.

Optional Feature:
- Macro: GLITCH_CNT_EN.
- Defined:
  - glitch_count port and an 8-bit register exist; reset value 0.
  - Each clk edge adds the number of channels (0-3) with a glitch abort that edge.
  - Saturates at 255; cleared only by reset.
- Undefined: port and logic absent. Debounce behaviour is otherwise identical.

Test Plan:
- WAIT=3, reset released, cs_pin held 0 from cycle 0 -> cs_c falls at edge 5, cs_fall high for one cycle, no other pulses.
- cs low, sclk_pin square wave at 16 clk period, mosi_pin pattern 1,0,1,1 set 4 clk before each rise -> four sclk_rise_sel pulses, each 5 edges after the pin rise. mosi_bit sequence is 1,0,1,1 and sclk_fall count is 4.
- sclk_pin high-pulse 2 clk wide with WAIT=3 -> sclk_c stays 0, no sclk_rise. With GLITCH_CNT_EN, glitch_count=1.
- cs_pin held 1, sclk_pin toggled 4 times (8 clk per level) -> sclk_rise=4, sclk_rise_sel=0, mosi_bit unchanged 0.
- reset_n pulsed low at edge 3 of a cs_pin falling transition -> no cs_fall. cs_c returns to 1 immediately, then falls 2+WAIT edges after release.
- GLITCH_CNT_EN, 300 single-clk glitches on all three pins -> glitch_count saturates at 255, conditioned lines unchanged.
